// File: rtl/wb_stage_pkg.sv
// Purpose: shared types/constants for the RV32I write-back stage slice.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: XLEN, funct3 load encodings, FSM state encoding, latched-load record.
package wb_stage_pkg;

    localparam int XLEN = 32;

    // Load funct3 encodings; anything else is handled as a full word.
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_WAIT_MEM = 1'b1
    } wb_state_e;

    // Everything about an outstanding load needed once its data returns.
    typedef struct packed {
        logic [4:0] rd;
        logic       wen;
        logic [2:0] funct3;
        logic [1:0] addr_lo;
    } load_info_t;

    // x0 is hardwired to zero, so a write to it is never presented to the regfile.
    function automatic logic wr_allowed(input logic wen, input logic [4:0] rd);
        return wen && (rd != 5'd0);
    endfunction

endpackage

// File: rtl/wb_stage_if.sv
// Purpose: bundles the write-back stage's execute, data-bus and regfile-port signals.
// Latency: n/a (signal bundle).
// Backpressure: ex_valid/ex_ready handshake; mem_rvalid and rd_en are unqualified pulses.
// Modports: master = surrounding pipeline (drives ex_*/mem_*), slave = wb_stage.
// Optional: WB_BYPASS_EN adds byp_valid/byp_addr/byp_data/byp_load_valid.
interface wb_stage_if #(
    parameter int XLEN = wb_stage_pkg::XLEN
);
    logic            ex_valid;
    logic            ex_ready;
    logic [4:0]      ex_rd_addr;
    logic            ex_rd_wen;
    logic [XLEN-1:0] ex_result;
    logic            ex_is_load;
    logic [2:0]      ex_funct3;
    logic [1:0]      ex_addr_lo;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd_data;
    logic            rd_en;
    logic            wb_busy;
`ifdef WB_BYPASS_EN
    logic            byp_valid;
    logic [4:0]      byp_addr;
    logic [XLEN-1:0] byp_data;
    logic            byp_load_valid;

    modport master (
        output ex_valid, ex_rd_addr, ex_rd_wen, ex_result, ex_is_load,
               ex_funct3, ex_addr_lo, mem_rvalid, mem_rdata,
        input  ex_ready, rd_addr, rd_data, rd_en, wb_busy,
               byp_valid, byp_addr, byp_data, byp_load_valid
    );
    modport slave (
        input  ex_valid, ex_rd_addr, ex_rd_wen, ex_result, ex_is_load,
               ex_funct3, ex_addr_lo, mem_rvalid, mem_rdata,
        output ex_ready, rd_addr, rd_data, rd_en, wb_busy,
               byp_valid, byp_addr, byp_data, byp_load_valid
    );
`else
    modport master (
        output ex_valid, ex_rd_addr, ex_rd_wen, ex_result, ex_is_load,
               ex_funct3, ex_addr_lo, mem_rvalid, mem_rdata,
        input  ex_ready, rd_addr, rd_data, rd_en, wb_busy
    );
    modport slave (
        input  ex_valid, ex_rd_addr, ex_rd_wen, ex_result, ex_is_load,
               ex_funct3, ex_addr_lo, mem_rvalid, mem_rdata,
        output ex_ready, rd_addr, rd_data, rd_en, wb_busy
    );
`endif
endinterface

// File: rtl/wb_stage_load_ext.sv
// Purpose: aligns a raw data-bus word and sign/zero-extends it per load funct3.
// Latency: combinational.
// Backpressure: none.
// Ports: rdata (raw word), funct3 (load type), addr_lo (byte offset) -> value.
module wb_stage_load_ext
    import wb_stage_pkg::*;
#(
    parameter int XLEN = wb_stage_pkg::XLEN
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    output logic [XLEN-1:0] value
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        // Halfword lane chosen by addr_lo[1]; addr_lo[0] is ignored (no misaligned support).
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        value = rdata;
        case (funct3)
            F3_LB:   value = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LBU:  value = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LH:   value = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_LHU:  value = {{(XLEN-16){1'b0}}, half_sel};
            F3_LW:   value = rdata;
            // Reserved encodings behave as LW.
            default: value = rdata;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Purpose: RV32I write-back stage; drives the regfile write port from execute results and load returns.
// Latency: non-load 1 cycle after accept; load 1 cycle after mem_rvalid.
// Backpressure: ex_ready low while a load waits for mem_rvalid; reopens in the rvalid cycle.
// Ports: clk, rst_n (async, active-low), bus (wb_stage_if.slave: ex_*, mem_*, rd_*, wb_busy).
// Optional: WB_BYPASS_EN adds combinational byp_* forwarding outputs.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int XLEN = wb_stage_pkg::XLEN
) (
    input  logic       clk,
    input  logic       rst_n,
    wb_stage_if.slave  bus
);

    wb_state_e       state;
    wb_state_e       state_nxt;
    load_info_t      ld_q;
    logic            ex_ready;
    logic            accept;
    logic            accept_alu;
    logic            accept_load;
    logic            load_rsp;
    logic [XLEN-1:0] ld_val;

    logic            rd_en_q;
    logic [4:0]      rd_addr_q;
    logic [XLEN-1:0] rd_data_q;

    // A non-load accepted in the rvalid cycle cannot share the write port with the
    // load result, so it waits here one cycle. While it is occupied, further
    // non-loads shift through it, keeping one write per cycle and program order.
    logic            pend_vld;
    logic            pend_en;
    logic [4:0]      pend_addr;
    logic [XLEN-1:0] pend_data;

    wb_stage_load_ext #(.XLEN(XLEN)) u_load_ext (
        .rdata   (bus.mem_rdata),
        .funct3  (ld_q.funct3),
        .addr_lo (ld_q.addr_lo),
        .value   (ld_val)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept_load) state_nxt = ST_WAIT_MEM;
            end
            ST_WAIT_MEM: begin
                if (bus.mem_rvalid) state_nxt = accept_load ? ST_WAIT_MEM : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs / handshake decode.
    always_comb begin
        load_rsp    = (state == ST_WAIT_MEM) && bus.mem_rvalid;
        ex_ready    = (state == ST_IDLE) || load_rsp;
        accept      = bus.ex_valid && ex_ready;
        accept_alu  = accept && !bus.ex_is_load;
        accept_load = accept && bus.ex_is_load;
    end

    // Write-port datapath. Priority: returning load, then the held non-load, then a fresh non-load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_en_q   <= 1'b0;
            rd_addr_q <= 5'd0;
            rd_data_q <= '0;
            pend_vld  <= 1'b0;
            pend_en   <= 1'b0;
            pend_addr <= 5'd0;
            pend_data <= '0;
            ld_q      <= '0;
        end else begin
            if (load_rsp) begin
                rd_en_q   <= wr_allowed(ld_q.wen, ld_q.rd);
                rd_addr_q <= ld_q.rd;
                rd_data_q <= ld_val;
            end else if (pend_vld) begin
                rd_en_q   <= pend_en;
                rd_addr_q <= pend_addr;
                rd_data_q <= pend_data;
            end else if (accept_alu) begin
                rd_en_q   <= wr_allowed(bus.ex_rd_wen, bus.ex_rd_addr);
                rd_addr_q <= bus.ex_rd_addr;
                rd_data_q <= bus.ex_result;
            end else begin
                rd_en_q   <= 1'b0;
            end

            pend_vld <= accept_alu && (load_rsp || pend_vld);
            if (accept_alu && (load_rsp || pend_vld)) begin
                pend_en   <= wr_allowed(bus.ex_rd_wen, bus.ex_rd_addr);
                pend_addr <= bus.ex_rd_addr;
                pend_data <= bus.ex_result;
            end

            if (accept_load) begin
                ld_q <= '{rd: bus.ex_rd_addr, wen: bus.ex_rd_wen,
                          funct3: bus.ex_funct3, addr_lo: bus.ex_addr_lo};
            end
        end
    end

    assign bus.ex_ready = ex_ready;
    assign bus.rd_en    = rd_en_q;
    assign bus.rd_addr  = rd_addr_q;
    assign bus.rd_data  = rd_data_q;
    // Decode of the state flop, so it is glitch-free for the hazard unit.
    assign bus.wb_busy  = (state == ST_WAIT_MEM);

`ifdef WB_BYPASS_EN
    // The load value is forwarded in its rvalid cycle, one cycle ahead of the regfile write.
    logic byp_load_valid;
    assign byp_load_valid     = load_rsp && wr_allowed(ld_q.wen, ld_q.rd);
    assign bus.byp_load_valid = byp_load_valid;
    assign bus.byp_valid      = rd_en_q;
    assign bus.byp_addr       = byp_load_valid ? ld_q.rd : rd_addr_q;
    assign bus.byp_data       = byp_load_valid ? ld_val  : rd_data_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Purpose: self-checking bench for wb_stage (directed, table-driven and random traffic).
// Latency: n/a.
// Backpressure: honours ex_ready; models load return delay with a random wait.
module tb_wb_stage;
    import wb_stage_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    wb_stage_if #(.XLEN(32)) bus();

    wb_stage #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  f3;
        logic [1:0]  lo;
        logic [31:0] rdata;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    vec_t vecs[13];
    wr_t  exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.ex_valid   = 1'b0;
        bus.ex_rd_addr = 5'd0;
        bus.ex_rd_wen  = 1'b0;
        bus.ex_result  = 32'd0;
        bus.ex_is_load = 1'b0;
        bus.ex_funct3  = 3'd0;
        bus.ex_addr_lo = 2'd0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'd0;
    endtask

    task automatic offer(input logic [4:0] rd, input logic wen, input logic ld,
                         input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] res);
        bus.ex_valid   = 1'b1;
        bus.ex_rd_addr = rd;
        bus.ex_rd_wen  = wen;
        bus.ex_is_load = ld;
        bus.ex_funct3  = f3;
        bus.ex_addr_lo = lo;
        bus.ex_result  = res;
    endtask

    // Reference: pick the addressed byte/halfword by shifting, then extend arithmetically.
    function automatic logic [31:0] ext_ref(input logic [2:0] f3, input logic [1:0] lo,
                                            input logic [31:0] rdata);
        logic [31:0] v;
        int unsigned off;
        off = lo;
        case (f3)
            3'b000, 3'b100: begin
                v = (rdata >> (8 * off)) & 32'h0000_00FF;
                if (f3 == 3'b000 && v >= 32'd128) v = v + 32'hFFFF_FF00;
            end
            3'b001, 3'b101: begin
                v = (rdata >> (16 * (off / 2))) & 32'h0000_FFFF;
                if (f3 == 3'b001 && v >= 32'd32768) v = v + 32'hFFFF_0000;
            end
            default: v = rdata;
        endcase
        return v;
    endfunction

    initial begin
        wr_t         w;
        logic        load_out;
        int          wait_cnt;
        logic [4:0]  l_rd;
        logic        l_wen;
        logic [2:0]  l_f3;
        logic [1:0]  l_lo;
        logic        rv;
        logic        exp_rdy;

        vecs[0]  = '{3'b000, 2'd2, 32'h1180_FF22, 32'hFFFF_FF80};
        vecs[1]  = '{3'b100, 2'd2, 32'h1180_FF22, 32'h0000_0080};
        vecs[2]  = '{3'b000, 2'd0, 32'h1180_FF22, 32'h0000_0022};
        vecs[3]  = '{3'b000, 2'd1, 32'h1180_FF22, 32'hFFFF_FFFF};
        vecs[4]  = '{3'b100, 2'd3, 32'h1180_FF22, 32'h0000_0011};
        vecs[5]  = '{3'b101, 2'd2, 32'h8001_0000, 32'h0000_8001};
        vecs[6]  = '{3'b001, 2'd2, 32'h8001_0000, 32'hFFFF_8001};
        vecs[7]  = '{3'b001, 2'd0, 32'h8001_7FFE, 32'h0000_7FFE};
        vecs[8]  = '{3'b001, 2'd1, 32'h1234_ABCD, 32'hFFFF_ABCD};
        vecs[9]  = '{3'b010, 2'd3, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[10] = '{3'b011, 2'd1, 32'hCAFE_F00D, 32'hCAFE_F00D};
        vecs[11] = '{3'b110, 2'd2, 32'h0000_FF80, 32'h0000_FF80};
        vecs[12] = '{3'b111, 2'd0, 32'h8000_0001, 32'h8000_0001};

        // Reset state.
        rst_n = 1'b0;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rd_en",   32'(bus.rd_en),    32'd0);
        chk("rst_rd_addr", 32'(bus.rd_addr),  32'd0);
        chk("rst_rd_data", bus.rd_data,       32'd0);
        chk("rst_wb_busy", 32'(bus.wb_busy),  32'd0);
        chk("rst_ex_ready", 32'(bus.ex_ready), 32'd1);
        rst_n = 1'b1;
        tick();

        // ALU write with 1-cycle latency, then a single pulse with held address/data.
        offer(5'd5, 1'b1, 1'b0, 3'd0, 2'd0, 32'h1234_5678);
        tick();
        bus.ex_valid = 1'b0;
        chk("alu_rd_en",   32'(bus.rd_en),   32'd1);
        chk("alu_rd_addr", 32'(bus.rd_addr), 32'd5);
        chk("alu_rd_data", bus.rd_data,      32'h1234_5678);
        tick();
        chk("alu_pulse_end", 32'(bus.rd_en),   32'd0);
        chk("alu_hold_addr", 32'(bus.rd_addr), 32'd5);
        chk("alu_hold_data", bus.rd_data,      32'h1234_5678);

        // Write to x0 is suppressed but data still updates.
        offer(5'd0, 1'b1, 1'b0, 3'd0, 2'd0, 32'hFFFF_FFFF);
        tick();
        bus.ex_valid = 1'b0;
        chk("x0_rd_en",   32'(bus.rd_en), 32'd0);
        chk("x0_rd_data", bus.rd_data,    32'hFFFF_FFFF);

        // LB with rvalid three cycles after accept.
        offer(5'd3, 1'b1, 1'b1, 3'b000, 2'd2, 32'h0);
        tick();
        bus.ex_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("lb_wait_busy", 32'(bus.wb_busy), 32'd1);
            chk("lb_wait_ready", 32'(bus.ex_ready), 32'd0);
            chk("lb_wait_rd_en", 32'(bus.rd_en), 32'd0);
            tick();
        end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h1180_FF22;
        #1;
        chk("lb_rsp_ready", 32'(bus.ex_ready), 32'd1);
        tick();
        bus.mem_rvalid = 1'b0;
        chk("lb_rd_en",   32'(bus.rd_en),   32'd1);
        chk("lb_rd_addr", 32'(bus.rd_addr), 32'd3);
        chk("lb_rd_data", bus.rd_data,      32'hFFFF_FF80);
        chk("lb_busy_clr", 32'(bus.wb_busy), 32'd0);

        // Extension table: each load answered one cycle after accept.
        for (int i = 0; i < 13; i++) begin
            offer(5'(i + 1), 1'b1, 1'b1, vecs[i].f3, vecs[i].lo, 32'h0);
            tick();
            bus.ex_valid   = 1'b0;
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = vecs[i].rdata;
            tick();
            bus.mem_rvalid = 1'b0;
            chk($sformatf("vec%0d_rd_en", i),   32'(bus.rd_en),   32'd1);
            chk($sformatf("vec%0d_rd_addr", i), 32'(bus.rd_addr), 32'(i + 1));
            chk($sformatf("vec%0d_rd_data", i), bus.rd_data,      vecs[i].exp);
        end

        // Overlap: ALU op offered in the rvalid cycle of a load.
        offer(5'd4, 1'b1, 1'b1, 3'b010, 2'd0, 32'h0);
        tick();
        bus.ex_valid = 1'b0;
        tick();
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hA5A5_5A5A;
        offer(5'd7, 1'b1, 1'b0, 3'd0, 2'd0, 32'h0000_0777);
        #1;
        chk("ovl_ready", 32'(bus.ex_ready), 32'd1);
        tick();
        drive_idle();
        chk("ovl_ld_en",   32'(bus.rd_en),   32'd1);
        chk("ovl_ld_addr", 32'(bus.rd_addr), 32'd4);
        chk("ovl_ld_data", bus.rd_data,      32'hA5A5_5A5A);
        tick();
        chk("ovl_alu_en",   32'(bus.rd_en),   32'd1);
        chk("ovl_alu_addr", 32'(bus.rd_addr), 32'd7);
        chk("ovl_alu_data", bus.rd_data,      32'h0000_0777);
        tick();
        chk("ovl_done", 32'(bus.rd_en), 32'd0);

        // Reset while a load is outstanding; a late rvalid must be ignored.
        offer(5'd9, 1'b1, 1'b1, 3'b010, 2'd0, 32'h0);
        tick();
        bus.ex_valid = 1'b0;
        chk("mid_busy", 32'(bus.wb_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy",  32'(bus.wb_busy),  32'd0);
        chk("mid_rst_ready", 32'(bus.ex_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        tick();
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h1357_9BDF;
        tick();
        bus.mem_rvalid = 1'b0;
        chk("mid_no_write", 32'(bus.rd_en),    32'd0);
        chk("mid_idle",     32'(bus.wb_busy),  32'd0);
        chk("mid_ready",    32'(bus.ex_ready), 32'd1);
        tick();
        chk("mid_no_write2", 32'(bus.rd_en), 32'd0);

        // Random traffic against an ordered write scoreboard.
        load_out = 1'b0;
        wait_cnt = 0;
        l_rd = 5'd0; l_wen = 1'b0; l_f3 = 3'd0; l_lo = 2'd0;
        for (int cyc = 0; cyc < 612; cyc++) begin
            if (bus.rd_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rnd_spurious_write: got write rd=%0d data=0x%08h expected none",
                             bus.rd_addr, bus.rd_data);
                end else begin
                    w = exp_q.pop_front();
                    chk("rnd_wr_addr", 32'(bus.rd_addr), 32'(w.a));
                    chk("rnd_wr_data", bus.rd_data, w.d);
                end
            end
            chk("rnd_busy", 32'(bus.wb_busy), 32'(load_out));

            rv = load_out && (wait_cnt == 0);
            if (load_out && !rv) wait_cnt--;
            bus.mem_rvalid = rv;
            bus.mem_rdata  = $urandom;

            bus.ex_valid   = (cyc < 600) && ($urandom_range(0, 3) != 0);
            bus.ex_rd_addr = 5'($urandom_range(0, 31));
            bus.ex_rd_wen  = ($urandom_range(0, 4) != 0);
            bus.ex_result  = $urandom;
            bus.ex_is_load = ($urandom_range(0, 2) == 0);
            bus.ex_funct3  = 3'($urandom_range(0, 7));
            bus.ex_addr_lo = 2'($urandom_range(0, 3));
            #1;
            exp_rdy = !load_out || rv;
            chk("rnd_ready", 32'(bus.ex_ready), 32'(exp_rdy));

            if (rv) begin
                if (l_wen && l_rd != 5'd0) exp_q.push_back('{l_rd, ext_ref(l_f3, l_lo, bus.mem_rdata)});
                load_out = 1'b0;
            end
            if (bus.ex_valid && exp_rdy) begin
                if (bus.ex_is_load) begin
                    load_out = 1'b1;
                    wait_cnt = $urandom_range(0, 3);
                    l_rd  = bus.ex_rd_addr;
                    l_wen = bus.ex_rd_wen;
                    l_f3  = bus.ex_funct3;
                    l_lo  = bus.ex_addr_lo;
                end else if (bus.ex_rd_wen && bus.ex_rd_addr != 5'd0) begin
                    exp_q.push_back('{bus.ex_rd_addr, bus.ex_result});
                end
            end
            tick();
        end
        drive_idle();
        chk("rnd_drain_empty", 32'(exp_q.size()), 32'd0);
        chk("rnd_final_busy", 32'(bus.wb_busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time bound so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
